// File: rtl/spi_slave_s2m_rx_if.sv
// Pin-side bundle for the SPI slave receiver: master drives CS/SCK/MOSI, slave returns frames.
// Latency: none, wires only.
// Backpressure: none; finish is a one-cycle strobe and out holds the last completed frame.
//   CS     chip select, active low, asynchronous to the system clock
//   SCK    SPI serial clock from the master
//   MOSI   serial data from the master
//   finish one-cycle pulse when a full frame has been received
//   out    last completed frame
interface spi_slave_s2m_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              CS;
    logic              SCK;
    logic              MOSI;
    logic              finish;
    logic [DATA_W-1:0] out;

    modport master (
        output CS,
        output SCK,
        output MOSI,
        input  finish,
        input  out
    );

    modport slave (
        input  CS,
        input  SCK,
        input  MOSI,
        output finish,
        output out
    );
endinterface

// File: rtl/spi_slave_s2m_rx.sv
// SPI slave receive front end: oversamples CS/SCK/MOSI on iclk and assembles serial bits into frames.
// Latency: finish rises SYNC_STAGES+1 iclk edges after the last sampling SCK edge reaches the pin.
// Backpressure: none; each frame is presented once with a one-cycle finish, out held until the next frame.
//   iclk  system clock (>= 4x SCK), rstn asynchronous active-low reset
//   bus   slave modport: CS/SCK/MOSI in, finish/out out
module spi_slave_s2m_rx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                iclk,
    input  logic                rstn,
    spi_slave_s2m_rx_if.slave   bus
);
    localparam int unsigned CNT_W       = $clog2(DATA_W + 1);
    localparam logic        SCK_IDLE    = (CPOL != 0);
    // Sampling on the falling SCK edge whenever exactly one of CPOL/CPHA is set.
    localparam logic        FALL_SAMPLE = ((CPOL != 0) != (CPHA != 0));
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;

    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      out_q,   out_d;
    logic                   finish_q, finish_d;

    logic cs_s, sck_s, mosi_s;
    logic cs_fall, sample_edge;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign cs_fall     = cs_prev_q & ~cs_s;
    // Edges only count while selected, so a deselect in the same cycle as the final edge drops the frame.
    assign sample_edge = ~cs_s & (FALL_SAMPLE ? (sck_prev_q & ~sck_s) : (~sck_prev_q & sck_s));

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= {SYNC_STAGES{SCK_IDLE}};
            mosi_sync_q <= '0;
            sck_prev_q  <= SCK_IDLE;
            cs_prev_q   <= 1'b1;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_q       <= '0;
            finish_q    <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.CS};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.SCK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_q       <= out_d;
            finish_q    <= finish_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        out_d    = out_q;
        finish_d = 1'b0;
        if (cs_s) begin
            // Deselected: discard any partial frame, keep the last completed one on out.
            cnt_d   = '0;
            shift_d = '0;
        end else begin
            if (cs_fall) begin
                cnt_d = '0;
            end
            if (sample_edge) begin
                if (MSB_FIRST != 0) begin
                    shift_d = {shift_q[DATA_W-2:0], mosi_s};
                end else begin
                    shift_d = {mosi_s, shift_q[DATA_W-1:1]};
                end
                if (cnt_d == LAST_BIT) begin
                    // Frame complete: publish including this final bit and wrap for the next frame.
                    cnt_d    = '0;
                    out_d    = shift_d;
                    finish_d = 1'b1;
                end else begin
                    cnt_d = cnt_d + CNT_W'(1);
                end
            end
        end
    end

    assign bus.finish = finish_q;
    assign bus.out    = out_q;
endmodule

// File: tb/tb_spi_slave_s2m_rx.sv
// Directed bench for spi_slave_s2m_rx: a mode-0 MSB-first build and a CPHA=1 LSB-first build.
// Latency: SCK half period is 4 iclk cycles (SCK = iclk/8).
// Backpressure: none; finish pulses are counted and captured by a negedge monitor.
module tb_spi_slave_s2m_rx;
    logic iclk;
    logic rstn;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    spi_slave_s2m_rx_if #(.DATA_W(8)) if0 ();
    spi_slave_s2m_rx_if #(.DATA_W(8)) if1 ();

    spi_slave_s2m_rx #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut0 (
        .iclk (iclk),
        .rstn (rstn),
        .bus  (if0.slave)
    );

    spi_slave_s2m_rx #(.DATA_W(8), .CPOL(0), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_dut1 (
        .iclk (iclk),
        .rstn (rstn),
        .bus  (if1.slave)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc++;

    int          fin_cnt0 = 0;
    int          fin_cnt1 = 0;
    int          f1_cyc   = 0;
    logic        fin_prev0 = 1'b0;
    logic        consec    = 1'b0;
    logic [7:0]  cap0[$];
    logic [47:0] asm48 = '0;

    always @(negedge iclk) begin
        if (if0.finish === 1'b1) begin
            fin_cnt0++;
            cap0.push_back(if0.out);
            asm48 = {if0.out, asm48[47:8]};
            if (fin_prev0) consec = 1'b1;
        end
        fin_prev0 = (if0.finish === 1'b1);
        if (if1.finish === 1'b1) begin
            fin_cnt1++;
            f1_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge iclk);
    endtask

    // Mode 0: data set while SCK low, sampled on the rising edge.
    task automatic send_bit0(input logic b);
        if0.MOSI = b;
        wait_cyc(4);
        if0.SCK = 1'b1;
        wait_cyc(4);
        if0.SCK = 1'b0;
    endtask

    task automatic send_byte0(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit0(d[i]);
    endtask

    int          base;
    int          qbase;
    int          e_cyc;
    logic [7:0]  exp6 [6];
    logic [7:0]  b6;

    initial begin
        exp6[0] = 8'h11; exp6[1] = 8'h22; exp6[2] = 8'h33;
        exp6[3] = 8'h44; exp6[4] = 8'h55; exp6[5] = 8'h66;
        rstn = 1'b0;
        if0.CS = 1'b1; if0.SCK = 1'b0; if0.MOSI = 1'b0;
        if1.CS = 1'b1; if1.SCK = 1'b0; if1.MOSI = 1'b0;
        wait_cyc(3);
        check("reset_out0", if0.out, 8'h00);
        check("reset_finish0", if0.finish, 1'b0);
        check("reset_out1", if1.out, 8'h00);
        rstn = 1'b1;
        wait_cyc(4);

        // SCK activity while deselected is ignored.
        base = fin_cnt0;
        if0.MOSI = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if0.SCK = 1'b1; wait_cyc(4);
            if0.SCK = 1'b0; wait_cyc(4);
        end
        wait_cyc(6);
        check("idle_sck_finish", fin_cnt0 - base, 0);
        check("idle_sck_out", if0.out, 8'h00);

        // Single frame 0xA5.
        base = fin_cnt0;
        if0.CS = 1'b0; wait_cyc(4);
        send_byte0(8'hA5);
        wait_cyc(4);
        if0.CS = 1'b1;
        wait_cyc(20);
        check("a5_count", fin_cnt0 - base, 1);
        check("a5_out", if0.out, 8'hA5);
        wait_cyc(20);
        check("a5_hold", if0.out, 8'hA5);

        // Six back-to-back frames under one selection.
        base  = fin_cnt0;
        qbase = cap0.size();
        asm48 = '0;
        if0.CS = 1'b0; wait_cyc(4);
        for (int k = 0; k < 6; k++) send_byte0(exp6[k]);
        wait_cyc(4);
        if0.CS = 1'b1;
        wait_cyc(20);
        check("b2b_count", fin_cnt0 - base, 6);
        for (int k = 0; k < 6; k++) begin
            b6 = (cap0.size() > qbase + k) ? cap0[qbase + k] : 8'hxx;
            check($sformatf("b2b_byte%0d", k), b6, exp6[k]);
        end
        check("b2b_assembled", asm48, 48'h665544332211);

        // Partial frame discarded on deselect, next full frame clean.
        base = fin_cnt0;
        if0.CS = 1'b0; wait_cyc(4);
        for (int i = 0; i < 5; i++) send_bit0(1'b1);
        wait_cyc(4);
        if0.CS = 1'b1; wait_cyc(8);
        if0.CS = 1'b0; wait_cyc(4);
        send_byte0(8'h3C);
        wait_cyc(4);
        if0.CS = 1'b1;
        wait_cyc(20);
        check("partial_count", fin_cnt0 - base, 1);
        check("partial_out", if0.out, 8'h3C);

        // Reset in the middle of a frame.
        base = fin_cnt0;
        if0.CS = 1'b0; wait_cyc(4);
        for (int i = 7; i >= 4; i--) send_bit0(i == 7);
        wait_cyc(2);
        rstn = 1'b0;
        if0.CS = 1'b1; if0.SCK = 1'b0;
        wait_cyc(2);
        check("midrst_out", if0.out, 8'h00);
        check("midrst_finish", if0.finish, 1'b0);
        rstn = 1'b1;
        wait_cyc(6);
        if0.CS = 1'b0; wait_cyc(4);
        send_byte0(8'h7E);
        wait_cyc(4);
        if0.CS = 1'b1;
        wait_cyc(20);
        check("midrst_count", fin_cnt0 - base, 1);
        check("midrst_out_7e", if0.out, 8'h7E);

        // CPHA=1, LSB-first: data changes on rising, sampled on falling.
        base   = fin_cnt1;
        f1_cyc = 0;
        if1.CS = 1'b0; wait_cyc(4);
        for (int i = 0; i < 8; i++) begin
            if1.SCK  = 1'b1;
            if1.MOSI = (i == 0);
            wait_cyc(4);
            if1.SCK  = 1'b0;
            e_cyc    = cyc;
            wait_cyc(4);
        end
        if1.CS = 1'b1;
        wait_cyc(20);
        check("cpha1_count", fin_cnt1 - base, 1);
        check("cpha1_out", if1.out, 8'h01);
        check("cpha1_latency", (f1_cyc > e_cyc) && (f1_cyc - e_cyc <= 4), 1'b1);

        check("no_consecutive_finish", consec, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
